// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority voting,
// optional even/odd parity and stop-bit checking.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic sync1, line, par_en_q, par_typ_q, par_err;
  logic [PRESCALE_WIDTH-1:0] p_q, edge_cnt, half;
  logic [BW-1:0] bit_cnt;
  logic [2:0] smp;
  logic [DATA_WIDTH-1:0] shreg;
  logic legal, wrap, decide, samp_pt, bit_val;
  assign legal = Prescale == PRESCALE_WIDTH'(8) || Prescale == PRESCALE_WIDTH'(16) ||
                 Prescale == PRESCALE_WIDTH'(32);
  assign half = p_q >> 1;
  assign wrap = edge_cnt == p_q - PRESCALE_WIDTH'(1);
  assign decide = edge_cnt == half + PRESCALE_WIDTH'(2);
  assign samp_pt = edge_cnt == half - PRESCALE_WIDTH'(1) || edge_cnt == half ||
                   edge_cnt == half + PRESCALE_WIDTH'(1);
  assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      line  <= sync1;
    end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      smp          <= '0;
      shreg        <= '0;
      p_q          <= PRESCALE_WIDTH'(16);
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_err      <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      edge_cnt     <= wrap ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
      if (samp_pt) smp <= {smp[1:0], line};
      case (state)
        IDLE: begin
          edge_cnt  <= '0;
          bit_cnt   <= '0;
          par_err   <= 1'b0;
          p_q       <= legal ? Prescale : PRESCALE_WIDTH'(16);
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          if (!line) state <= START;
        end
        START: begin
          if (decide && bit_val) state <= IDLE;
          else if (wrap) state <= DATA;
        end
        DATA: begin
          if (decide) shreg <= DATA_WIDTH'({bit_val, shreg} >> 1);
          if (wrap) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (decide) par_err <= bit_val != (^shreg ^ par_typ_q);
          if (wrap) state <= STOP;
        end
        STOP: begin
          // leave at the decision point so a back-to-back start bit is not missed
          if (decide) begin
            state        <= IDLE;
            data_valid   <= bit_val && !par_err;
            parity_error <= par_err;
            stop_error   <= !bit_val;
            if (bit_val && !par_err) P_DATA <= shreg;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames covering prescales, parity, stop errors,
// glitches, back-to-back frames and mid-frame reset.
module tb_uart_rx;
  logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd16;
  logic [7:0] P_DATA;
  logic data_valid, parity_error, stop_error;
  int n_cmp = 0, n_err = 0, n_dv = 0, n_pe = 0, n_se = 0;
  int dv0, pe0, se0;
  logic [7:0] dv_log [$];
  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .data_valid(data_valid),
    .parity_error(parity_error), .stop_error(stop_error)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (data_valid) begin
      n_dv++;
      dv_log.push_back(P_DATA);
    end
    if (parity_error) n_pe++;
    if (stop_error) n_se++;
  end
  initial begin
    #500000;
    $error("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic v, input int p);
    RX_IN = v;
    repeat (p) @(posedge CLK);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pb,
                            input logic sb, input int idle);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pe) send_bit(pb, p);
    send_bit(sb, p);
    send_bit(1'b1, idle);
  endtask
  task automatic mark;
    dv0 = n_dv;
    pe0 = n_pe;
    se0 = n_se;
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_pe", parity_error, 1'b0);
    chk("rst_se", stop_error, 1'b0);
    RST = 1'b1;
    send_bit(1'b1, 5);
    Prescale = 6'd8; PAR_EN = 1'b0;
    mark();
    send_bit(1'b1, 2);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
    chk("a5_dv", n_dv - dv0, 1);
    chk("a5_pdata", P_DATA, 8'hA5);
    chk("a5_err", (n_pe - pe0) + (n_se - se0), 0);
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    mark();
    send_bit(1'b1, 2);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 32);
    chk("3c_even_dv", n_dv - dv0, 1);
    chk("3c_even_pdata", P_DATA, 8'h3C);
    chk("3c_even_err", (n_pe - pe0) + (n_se - se0), 0);
    mark();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 32);
    chk("3c_bad_pe", n_pe - pe0, 1);
    chk("3c_bad_dv", n_dv - dv0, 0);
    chk("3c_bad_se", n_se - se0, 0);
    chk("3c_bad_pdata", P_DATA, 8'h3C);
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    mark();
    send_bit(1'b1, 2);
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, 80);
    chk("stop_se", n_se - se0, 1);
    chk("stop_pe", n_pe - pe0, 0);
    chk("stop_dv", n_dv - dv0, 0);
    chk("stop_pdata", P_DATA, 8'h3C);
    mark();
    send_frame(8'h81, 32, 1'b1, 1'b1, 1'b1, 64);
    chk("odd_dv", n_dv - dv0, 1);
    chk("odd_pdata", P_DATA, 8'h81);
    chk("odd_err", (n_pe - pe0) + (n_se - se0), 0);
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    mark();
    send_bit(1'b1, 2);
    send_bit(1'b0, 3);
    send_bit(1'b1, 40);
    chk("glitch_pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 32);
    chk("55_dv", n_dv - dv0, 1);
    chk("55_pdata", P_DATA, 8'h55);
    Prescale = 6'd8;
    mark();
    send_bit(1'b1, 2);
    dv_log.delete();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 16);
    chk("b2b_dv", n_dv - dv0, 2);
    chk("b2b_first", dv_log.size() > 0 ? dv_log[0] : 8'hxx, 8'h12);
    chk("b2b_second", dv_log.size() > 1 ? dv_log[1] : 8'hxx, 8'h34);
    chk("b2b_err", (n_pe - pe0) + (n_se - se0), 0);
    Prescale = 6'd16;
    mark();
    send_bit(1'b1, 2);
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 5);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_pdata", P_DATA, 8'h00);
    chk("mid_rst_dv", data_valid, 1'b0);
    chk("mid_rst_pe", parity_error, 1'b0);
    chk("mid_rst_se", stop_error, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    send_bit(1'b1, 120);
    chk("mid_rst_pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
    send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1, 32);
    chk("0f_dv", n_dv - dv0, 1);
    chk("0f_pdata", P_DATA, 8'h0F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter PRESCALE_WIDTH, default 6: width of the Prescale port.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  receiver clock, rising-edge active.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-007 Prescale  input  PRESCALE_WIDTH  oversampling ratio, CLK cycles per bit; legal values 8, 16, 32.
REQ-008 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-009 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-010 P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-011 data_valid  output  1  one-cycle pulse when P_DATA holds a new good word.
REQ-012 parity_error  output  1  one-cycle pulse on parity mismatch.
REQ-013 stop_error  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-014 RX_IN SHALL pass through a 2-flop synchronizer (both flops reset to 1); "line" below means the synchronized value.
REQ-015 Prescale values other than 8/16/32 SHALL behave as 16; Prescale SHALL be sampled only in IDLE and held for the frame.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; encoding is free.
REQ-017 Edge counter edge_cnt SHALL count 0..Prescale-1 within each bit, wrap to 0, and advance the bit position on wrap.
REQ-018 Bit value SHALL be the majority of 3 line samples taken at edge_cnt = P/2-1, P/2, P/2+1 (P = Prescale); the decision is available at edge_cnt = P/2+2.
REQ-019 IDLE -> START when the line is 0; edge_cnt = 0 on the first START cycle.
REQ-020 START: a majority of 1 SHALL be a glitch -> IDLE with no output pulses; a majority of 0 -> DATA on wrap.
REQ-021 DATA SHALL receive DATA_WIDTH bits, LSB first, into a shift register; after the last bit -> PARITY if PAR_EN = 1, else -> STOP.
REQ-022 PARITY: expected bit = XOR of data bits (even) or its inverse (odd); a mismatch latches a parity flag for this frame; -> STOP on wrap.
REQ-023 STOP: at the decision point (edge_cnt = P/2+2) the FSM SHALL return to IDLE on the next cycle, without waiting for the rest of the stop bit, so a back-to-back start bit is caught.
REQ-024 In the cycle after the STOP decision, the block SHALL assert exactly one of:
- data_valid, with P_DATA loaded, when parity (if enabled) and stop are both good;
- parity_error on a parity mismatch;
- stop_error when the stop bit majority is 0.
If both errors occur, parity_error and stop_error SHALL pulse together.
REQ-025 P_DATA SHALL change only on a data_valid cycle; on error it SHALL hold its previous value.
REQ-026 All pulses SHALL be exactly one CLK wide.
REQ-027 PAR_EN/PAR_TYP changes mid-frame are unsupported; they SHALL be sampled in IDLE with Prescale.

Reset
REQ-028 On RST low, asynchronously:
- FSM = IDLE, counters = 0;
- synchronizer flops = 1;
- P_DATA = 0, data_valid = 0, parity_error = 0, stop_error = 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no pulses; after release the block SHALL wait for a fresh 1->0 transition on the line.

Verification
REQ-030 Prescale=8, PAR_EN=0, frame 0xA5 (start, 10100101 LSB first, stop) -> P_DATA=0xA5, one data_valid pulse, no errors.
REQ-031 Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 0 -> data_valid, P_DATA=0x3C; same frame with parity bit 1 -> parity_error pulse, P_DATA stays 0x3C, no data_valid.
REQ-032 Prescale=32, PAR_EN=1, PAR_TYP=1, data 0x01 with parity 0 and stop bit driven 0 -> stop_error pulse only; line back to 1 -> next good frame accepted.
REQ-033 Prescale=16, line low for 3 cycles then high -> return to IDLE, no pulses; a following valid frame 0x55 -> data_valid, P_DATA=0x55.
REQ-034 Two back-to-back frames 0x12, 0x34 with a single stop bit, Prescale=8 -> two data_valid pulses in order, P_DATA 0x12 then 0x34.
REQ-035 RST asserted during DATA bit 4 of frame 0xFF -> all outputs 0 immediately, no pulse; next frame 0x0F -> P_DATA=0x0F.
